// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window controller.
package conv_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Number of window positions along one axis of the image.
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

endpackage

// File: rtl/stride_phase_cnt.sv
// One axis of the raster position tracker: a wrapping position counter plus a
// stride phase counter that is zero exactly on the window-completing positions.
// i_load makes the current beat behave as position 0 (start of frame).
module stride_phase_cnt #(
  parameter int N      = 32,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int W      = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_adv,
  output logic [W-1:0] o_pos,
  output logic         o_at_last,
  output logic         o_hit
);

  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [W-1:0]  POS_LAST  = W'(N - 1);
  localparam logic [W-1:0]  POS_FIRST = W'(K - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);

  logic [W-1:0]  r_pos;
  logic [PW-1:0] r_ph;
  logic [W-1:0]  w_pos;
  logic [W-1:0]  w_pos_nx;
  logic [PW-1:0] w_ph;
  logic [PW-1:0] w_ph_nx;
  logic          w_in_win;

  // Effective position for this beat, window test and next-state values.
  always_comb begin
    w_pos     = i_load ? '0 : r_pos;
    w_ph      = i_load ? '0 : r_ph;
    w_in_win  = (w_pos >= POS_FIRST);
    o_at_last = (w_pos == POS_LAST);
    o_hit     = w_in_win && (w_ph == '0);
    w_pos_nx  = o_at_last ? '0 : w_pos + 1'b1;
    if (o_at_last || !w_in_win)
      w_ph_nx = '0;
    else if (w_ph == PH_LAST)
      w_ph_nx = '0;
    else
      w_ph_nx = w_ph + 1'b1;
  end

  // Position and phase registers; a load without advance still restarts the axis.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos <= '0;
      r_ph  <= '0;
    end else if (i_adv) begin
      r_pos <= w_pos_nx;
      r_ph  <= w_ph_nx;
    end else if (i_load) begin
      r_pos <= '0;
      r_ph  <= '0;
    end
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/conv_window_ctrl.sv
// Valid-window controller: tracks raster position of accepted pixels, flags
// the ones completing a KxK window at STRIDE, and reports output coordinates,
// row/frame ends and frame completion.
// Optional sticky framing error output o_err: define CONV_WINDOW_CTRL_ERR_EN.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int STRIDE = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  input  logic i_sof,
  output logic o_valid,
  output logic [((out_dim(IMG_W, K, STRIDE) > 1) ? $clog2(out_dim(IMG_W, K, STRIDE)) : 1)-1:0] o_col,
  output logic [((out_dim(IMG_H, K, STRIDE) > 1) ? $clog2(out_dim(IMG_H, K, STRIDE)) : 1)-1:0] o_row,
  output logic o_eol,
  output logic o_eof,
  output logic o_frame_done,
  output logic o_busy
`ifdef CONV_WINDOW_CTRL_ERR_EN
  ,
  output logic o_err
`endif
);

  localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H = out_dim(IMG_H, K, STRIDE);
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int OCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ORW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam logic [OCW-1:0] OC_LAST = OCW'(OUT_W - 1);
  localparam logic [ORW-1:0] OR_LAST = ORW'(OUT_H - 1);

  state_t         r_state;
  logic           r_valid;
  logic [OCW-1:0] r_col;
  logic [ORW-1:0] r_row;
  logic           r_eol;
  logic           r_eof;
  logic           r_frame_done;
  logic [OCW-1:0] r_oc_nx;
  logic [ORW-1:0] r_or_nx;

  logic [CW-1:0]  w_col_pos;
  logic [RW-1:0]  w_row_pos;
  logic           w_col_last;
  logic           w_row_last;
  logic           w_col_hit;
  logic           w_row_hit;
  logic           w_load;
  logic           w_hit;
  logic           w_last_pix;
  logic [OCW-1:0] w_oc;
  logic [ORW-1:0] w_or;
  logic           w_eol;
  logic           w_eof;

  assign w_load = i_valid && i_sof;

  stride_phase_cnt #(
    .N(IMG_W), .K(K), .STRIDE(STRIDE), .W(CW)
  ) u_col (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load),
    .i_adv     (i_valid),
    .o_pos     (w_col_pos),
    .o_at_last (w_col_last),
    .o_hit     (w_col_hit)
  );

  stride_phase_cnt #(
    .N(IMG_H), .K(K), .STRIDE(STRIDE), .W(RW)
  ) u_row (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load),
    .i_adv     (i_valid && w_col_last),
    .o_pos     (w_row_pos),
    .o_at_last (w_row_last),
    .o_hit     (w_row_hit)
  );

  // Window qualification and output coordinate for the pixel on the input this cycle.
  always_comb begin
    w_hit      = i_valid && w_col_hit && w_row_hit;
    w_last_pix = i_valid && w_col_last && w_row_last;
    w_oc       = w_load ? '0 : r_oc_nx;
    w_or       = w_load ? '0 : r_or_nx;
    w_eol      = (w_oc == OC_LAST);
    w_eof      = w_eol && (w_or == OR_LAST);
  end

  // Frame state: any accepted pixel starts a frame, the last raster pixel ends it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= IDLE;
    else if (i_valid)
      r_state <= w_last_pix ? IDLE : ACTIVE;
  end

  // Output coordinate counters, advanced once per qualifying window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_oc_nx <= '0;
      r_or_nx <= '0;
    end else if (w_hit) begin
      if (w_eol) begin
        r_oc_nx <= '0;
        r_or_nx <= w_eof ? '0 : w_or + 1'b1;
      end else begin
        r_oc_nx <= w_oc + 1'b1;
        r_or_nx <= w_or;
      end
    end else if (w_load) begin
      r_oc_nx <= '0;
      r_or_nx <= '0;
    end
  end

  // Registered output stream; coordinates hold between windows.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid      <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_eol        <= 1'b0;
      r_eof        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid      <= w_hit;
      r_eol        <= w_hit && w_eol;
      r_eof        <= w_hit && w_eof;
      r_frame_done <= w_last_pix;
      if (w_hit) begin
        r_col <= w_oc;
        r_row <= w_or;
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_col        = r_col;
  assign o_row        = r_row;
  assign o_eol        = r_eol;
  assign o_eof        = r_eof;
  assign o_frame_done = r_frame_done;
  assign o_busy       = (r_state == ACTIVE);

`ifdef CONV_WINDOW_CTRL_ERR_EN
  logic r_err;
  logic r_done_seen;
  logic w_trunc;
  logic w_nosof;

  assign w_trunc = w_load && (r_state == ACTIVE) && ((w_col_pos != '0) || (w_row_pos != '0));
  assign w_nosof = i_valid && !i_sof && (r_state == IDLE) && r_done_seen;

  // Sticky framing error: SOF cutting a frame short, or a frame started without SOF.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err       <= 1'b0;
      r_done_seen <= 1'b0;
    end else begin
      if (i_valid)
        r_done_seen <= w_last_pix;
      if (w_trunc || w_nosof)
        r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_pos;
  assign w_unused_pos = ^{w_col_pos, w_row_pos};
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: default 32x32 K5 S1, 8x8 K3 S2, 4x4 K1.
module tb_conv_window_ctrl;

  logic clk;
  logic rst_n;
  logic clr;
  logic a_valid, a_sof, b_valid, b_sof, c_valid, c_sof;

  logic       a_ov, a_oeol, a_oeof, a_ofd, a_busy;
  logic [4:0] a_oc, a_or;
  logic       b_ov, b_oeol, b_oeof, b_ofd, b_busy;
  logic [1:0] b_oc, b_or;
  logic       c_ov, c_oeol, c_oeof, c_ofd, c_busy;
  logic [1:0] c_oc, c_or;
`ifdef CONV_WINDOW_CTRL_ERR_EN
  logic a_err, b_err, c_err;
`endif

  int n_total = 0;
  int n_pass  = 0;

  conv_window_ctrl u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .i_sof(a_sof),
    .o_valid(a_ov), .o_col(a_oc), .o_row(a_or), .o_eol(a_oeol), .o_eof(a_oeof),
    .o_frame_done(a_ofd), .o_busy(a_busy)
`ifdef CONV_WINDOW_CTRL_ERR_EN
    , .o_err(a_err)
`endif
  );

  conv_window_ctrl #(.IMG_W(8), .IMG_H(8), .K(3), .STRIDE(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .i_sof(b_sof),
    .o_valid(b_ov), .o_col(b_oc), .o_row(b_or), .o_eol(b_oeol), .o_eof(b_oeof),
    .o_frame_done(b_ofd), .o_busy(b_busy)
`ifdef CONV_WINDOW_CTRL_ERR_EN
    , .o_err(b_err)
`endif
  );

  conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .K(1), .STRIDE(1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(c_valid), .i_sof(c_sof),
    .o_valid(c_ov), .o_col(c_oc), .o_row(c_or), .o_eol(c_oeol), .o_eof(c_oeof),
    .o_frame_done(c_ofd), .o_busy(c_busy)
`ifdef CONV_WINDOW_CTRL_ERR_EN
    , .o_err(c_err)
`endif
  );

  always #5 clk = ~clk;

  // Monitor A: counts windows and checks the coordinate sequence (28x28 outputs).
  int a_acc, a_nv, a_first, a_neof, a_nfd, a_fd_idx, a_bad, a_ec, a_er, a_lc, a_lr, a_leof;
  logic a_prev;
  always @(negedge clk) begin
    if (!rst_n || clr) begin
      a_acc = 0; a_prev = 0; a_nv = 0; a_first = -1; a_neof = 0; a_nfd = 0;
      a_fd_idx = -1; a_bad = 0; a_ec = 0; a_er = 0; a_lc = 0; a_lr = 0; a_leof = 0;
    end else begin
      if (a_ov) begin
        if (!a_prev) a_bad++;
        if (a_nv == 0) a_first = a_acc - 1;
        a_nv++;
        if (a_oc !== 5'(a_ec) || a_or !== 5'(a_er)) a_bad++;
        if (a_oeol !== (a_ec == 27)) a_bad++;
        if (a_oeof !== (a_ec == 27 && a_er == 27)) a_bad++;
        if (a_oeof) a_neof++;
        a_lc = a_oc; a_lr = a_or; a_leof = a_oeof;
        if (a_ec == 27) begin a_ec = 0; a_er = (a_er == 27) ? 0 : a_er + 1; end
        else a_ec++;
      end else if (a_oeol || a_oeof) a_bad++;
      if (a_ofd) begin a_nfd++; a_fd_idx = a_acc - 1; end
      if (a_valid && a_sof) begin a_acc = 1; a_ec = 0; a_er = 0; end
      else if (a_valid) a_acc++;
      a_prev = a_valid;
    end
  end

  // Monitor B: 3x3 outputs, records the input index of every window.
  int b_acc, b_nv, b_neol, b_neof, b_eof_idx, b_nfd, b_fd_idx, b_bad, b_ec, b_er;
  int b_idx [16];
  logic b_prev;
  always @(negedge clk) begin
    if (!rst_n || clr) begin
      b_acc = 0; b_prev = 0; b_nv = 0; b_neol = 0; b_neof = 0; b_eof_idx = -1;
      b_nfd = 0; b_fd_idx = -1; b_bad = 0; b_ec = 0; b_er = 0;
      for (int i = 0; i < 16; i++) b_idx[i] = -1;
    end else begin
      if (b_ov) begin
        if (!b_prev) b_bad++;
        if (b_nv < 16) b_idx[b_nv] = b_acc - 1;
        b_nv++;
        if (b_oc !== 2'(b_ec) || b_or !== 2'(b_er)) b_bad++;
        if (b_oeol !== (b_ec == 2)) b_bad++;
        if (b_oeof !== (b_ec == 2 && b_er == 2)) b_bad++;
        if (b_oeol) b_neol++;
        if (b_oeof) begin b_neof++; b_eof_idx = b_acc - 1; end
        if (b_ec == 2) begin b_ec = 0; b_er = (b_er == 2) ? 0 : b_er + 1; end
        else b_ec++;
      end else if (b_oeol || b_oeof) b_bad++;
      if (b_ofd) begin b_nfd++; b_fd_idx = b_acc - 1; end
      if (b_valid) b_acc++;
      b_prev = b_valid;
    end
  end

  // Monitor C: K=1 4x4, every pixel is a window.
  int c_acc, c_nv, c_first, c_neol, c_neof, c_eof_idx, c_nfd, c_bad, c_ec, c_er;
  logic c_prev;
  always @(negedge clk) begin
    if (!rst_n || clr) begin
      c_acc = 0; c_prev = 0; c_nv = 0; c_first = -1; c_neol = 0; c_neof = 0;
      c_eof_idx = -1; c_nfd = 0; c_bad = 0; c_ec = 0; c_er = 0;
    end else begin
      if (c_ov) begin
        if (!c_prev) c_bad++;
        if (c_nv == 0) c_first = c_acc - 1;
        c_nv++;
        if (c_oc !== 2'(c_ec) || c_or !== 2'(c_er)) c_bad++;
        if (c_oeol !== (c_ec == 3)) c_bad++;
        if (c_oeof !== (c_ec == 3 && c_er == 3)) c_bad++;
        if (c_oeol) c_neol++;
        if (c_oeof) begin c_neof++; c_eof_idx = c_acc - 1; end
        if (c_ec == 3) begin c_ec = 0; c_er = (c_er == 3) ? 0 : c_er + 1; end
        else c_ec++;
      end else if (c_oeol || c_oeof) c_bad++;
      if (c_ofd) c_nfd++;
      if (c_valid) c_acc++;
      c_prev = c_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive(input int d, input logic s);
    @(posedge clk); #1;
    a_valid = (d == 0); a_sof = (d == 0) && s;
    b_valid = (d == 1); b_sof = (d == 1) && s;
    c_valid = (d == 2); c_sof = (d == 2) && s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      a_valid = 0; a_sof = 0; b_valid = 0; b_sof = 0; c_valid = 0; c_sof = 0;
    end
  endtask

  task automatic clear();
    idle(1);
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
  endtask

  task automatic chk_a_frame(input string tag);
    chk({tag, "_nvalid"}, a_nv, 784);
    chk({tag, "_first_idx"}, a_first, 132);
    chk({tag, "_last_col"}, a_lc, 27);
    chk({tag, "_last_row"}, a_lr, 27);
    chk({tag, "_last_eof"}, a_leof, 1);
    chk({tag, "_neof"}, a_neof, 1);
    chk({tag, "_nframe_done"}, a_nfd, 1);
    chk({tag, "_seq_errors"}, a_bad, 0);
    chk({tag, "_busy_end"}, a_busy, 0);
  endtask

  initial begin
    clk = 0; rst_n = 0; clr = 0;
    a_valid = 0; a_sof = 0; b_valid = 0; b_sof = 0; c_valid = 0; c_sof = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", a_ov, 0);
    chk("rst_col", a_oc, 0);
    chk("rst_row", a_or, 0);
    chk("rst_eol", a_oeol, 0);
    chk("rst_eof", a_oeof, 0);
    chk("rst_frame_done", a_ofd, 0);
    chk("rst_busy", a_busy, 0);
    rst_n = 1;
    idle(2);
    chk("idle_valid", a_ov, 0);

    // Back-to-back default frame
    for (int i = 0; i < 1024; i++) begin
      drive(0, 0);
      if (i == 10) begin
        @(negedge clk);
        chk("busy_mid", a_busy, 1);
      end
    end
    idle(4);
    chk_a_frame("b2b");
    chk("b2b_fd_idx", a_fd_idx, 1023);
    chk("hold_col", a_oc, 27);
    chk("hold_row", a_or, 27);
    chk("hold_valid", a_ov, 0);
`ifdef CONV_WINDOW_CTRL_ERR_EN
    chk("err_clean", a_err, 0);
`endif

    // Gapped input stream
    clear();
    for (int i = 0; i < 1024; i++) begin
      drive(0, 0);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(4);
    chk_a_frame("gap");
    chk("gap_fd_idx", a_fd_idx, 1023);

    // SOF abort at pixel 500, then a full SOF frame
    clear();
    for (int i = 0; i < 500; i++) drive(0, 0);
    chk("abort_busy", a_busy, 1);
    clear();
    for (int i = 0; i < 1024; i++) drive(0, (i == 0));
    idle(4);
    chk_a_frame("abort");
    chk("abort_fd_idx", a_fd_idx, 1023);
`ifdef CONV_WINDOW_CTRL_ERR_EN
    chk("err_sticky", a_err, 1);
`endif

    // Reset mid-frame at pixel 300
    clear();
    for (int i = 0; i < 300; i++) drive(0, 0);
    @(posedge clk); #1;
    a_valid = 0; rst_n = 0;
    #1;
    chk("mrst_valid", a_ov, 0);
    chk("mrst_col", a_oc, 0);
    chk("mrst_row", a_or, 0);
    chk("mrst_eol", a_oeol, 0);
    chk("mrst_busy", a_busy, 0);
    chk("mrst_frame_done", a_ofd, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    clear();
    for (int i = 0; i < 1024; i++) drive(0, 0);
    idle(4);
    chk_a_frame("mrst");

    // 8x8 K=3 STRIDE=2
    clear();
    for (int i = 0; i < 64; i++) drive(1, (i == 0));
    idle(4);
    chk("s2_nvalid", b_nv, 9);
    begin
      int exp_idx [9];
      exp_idx = '{18, 20, 22, 34, 36, 38, 50, 52, 54};
      for (int i = 0; i < 9; i++) chk($sformatf("s2_idx%0d", i), b_idx[i], exp_idx[i]);
    end
    chk("s2_neol", b_neol, 3);
    chk("s2_neof", b_neof, 1);
    chk("s2_eof_idx", b_eof_idx, 54);
    chk("s2_nframe_done", b_nfd, 1);
    chk("s2_fd_idx", b_fd_idx, 63);
    chk("s2_seq_errors", b_bad, 0);
    chk("s2_hold_col", b_oc, 2);

    // 4x4 K=1
    clear();
    for (int i = 0; i < 16; i++) drive(2, 0);
    idle(4);
    chk("k1_nvalid", c_nv, 16);
    chk("k1_first_idx", c_first, 0);
    chk("k1_neol", c_neol, 4);
    chk("k1_neof", c_neof, 1);
    chk("k1_eof_idx", c_eof_idx, 15);
    chk("k1_nframe_done", c_nfd, 1);
    chk("k1_seq_errors", c_bad, 0);
    chk("k1_busy_end", c_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
